md_ctrl: RTL and testbench
==========================

// Module: md_ctrl
// PURPOSE
//  EX-stage multiply/divide controller with the HI/LO register pair. Decodes MD ops from the pipeline,
//  runs MULT/MULTU on an internal fixed-latency multiplier and issues DIV/DIVU to the downstream iterative
//  divider over a valid/ready handshake. Writes results into HI/LO, serves MFHI/MFLO reads and raises busy for the stall unit.
// PARAMETERS
//  MUL_CYCLES  5  cycles busy stays high for MULT/MULTU (>=1)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  md_start       in   1   EX holds a valid MD op this cycle
//  md_op          in   4   NONE=0 MULT=1 MULTU=2 DIV=3 DIVU=4 MFHI=5 MFLO=6 MTHI=7 MTLO=8
//  req            in   1   exception/interrupt flush; suppresses md_start this cycle
//  rs_data        in   32  operand A / dividend / MTHI,MTLO source
//  rt_data        in   32  operand B / divisor
//  md_rd          out  32  MFHI ? HI : MFLO ? LO : 0 (combinational on md_op)
//  busy           out  1   state != IDLE
//  div_src0       out  32  latched dividend
//  div_src1       out  32  latched divisor
//  div_op         out  2   2'b10 (DIV) while div_in_valid, else 2'b00
//  div_sign       out  1   1 for DIV, 0 for DIVU
//  div_in_valid   out  1   request to divider
//  div_in_ready   in   1   divider idle
//  div_out_ready  out  1   ready to take the divider result
//  div_out_valid  in   1   divider result valid
//  div_res0       in   32  quotient  -> LO
//  div_res1       in   32  remainder -> HI
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, latched operands 0, count 0; all outputs 0 the cycle after reset.
//  Reset mid-operation aborts at once. The divider shares this reset, so no handshake is left pending.
//  go = md_start & !req. It is sampled only in IDLE. In other states md_start is ignored (the stall unit guarantees this).
//  States:
//   IDLE:
//    go&MULT/MULTU: latch rs,rt and sign; count<=MUL_CYCLES-1 -> MUL_RUN
//    go&DIV/DIVU, rt!=0: latch rs,rt and sign -> DIV_REQ
//    go&DIV/DIVU, rt==0: no state or HI/LO change, no divider issue, busy stays 0
//    go&MTHI: HI<=rs at this edge; go&MTLO: LO<=rs at this edge; stay IDLE
//    MFHI/MFLO: read only, no state change
//   MUL_RUN: count--. When count==0: {HI,LO} <= signed or unsigned 64-bit product of the latched operands -> IDLE.
//    busy is high exactly MUL_CYCLES cycles. Product is full 64-bit: signed(32)*signed(32) or zero-extended.
//   DIV_REQ: div_in_valid=1 and operands held stable; on div_in_valid&div_in_ready -> DIV_WAIT.
//   DIV_WAIT: div_out_ready=1; on div_out_valid: HI<=div_res1, LO<=div_res0 -> IDLE.
//  DIV latency = 1 + divider latency + 1 edge. HI/LO are updated on exactly one edge per op.
//  MFHI issued the cycle after a HI write returns the new value (register read, no bypass needed).
//  req during MUL_RUN/DIV_* does not cancel the op; only new starts are gated.
// STRUCTURE
//  Shared package md_pkg: md_op encodings, state encoding (IDLE/MUL_RUN/DIV_REQ/DIV_WAIT), divider op codes (IDLE=00, MUL=01, DIV=10).
//  One natural sub-module: md_mul_core, the registered 64-bit signed/unsigned multiplier. Divider is instantiated outside by the EX stage.
// TESTING (divider bench model: correct signed/unsigned div, 10-cycle latency, in_ready=!busy)
//  MULT rs=0xFFFFFFFD(-3) rt=7 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB
//  MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001
//  DIV rs=0xFFFFFFF9(-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=7 rt=2 -> LO=3, HI=1; div_in_valid high 1 cycle
//  DIV rt=0 with HI=0xAA, LO=0xBB -> HI/LO unchanged, busy and div_in_valid never asserted
//  MTHI rs=0x12345678, then MFHI next cycle -> md_rd=0x12345678; MULT with req=1 -> busy stays 0, HI/LO unchanged
//  reset asserted in DIV_WAIT -> next cycle busy=0, HI=LO=0, div_in_valid=div_out_ready=0

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the EX-stage multiply/divide controller.
// Holds MD op codes, FSM states, divider op codes and an operand extender.
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_RUN  = 2'd1,
        S_DIV_REQ  = 2'd2,
        S_DIV_WAIT = 2'd3
    } md_state_e;

    localparam logic [1:0] DOP_IDLE = 2'b00;
    localparam logic [1:0] DOP_MUL  = 2'b01;
    localparam logic [1:0] DOP_DIV  = 2'b10;

    // Sign- or zero-extend to 64 bits; the low 64 bits of a 64x64
    // product are then correct for both signed and unsigned operands.
    function automatic logic [63:0] ext64(
        input logic [31:0] v,
        input logic        s
    );
        return {{32{s & v[31]}}, v};
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// md_ctrl_if: valid/ready link between md_ctrl and the iterative divider.
// master = controller (issues operands, takes result), slave = divider.
interface md_ctrl_if;

    logic [31:0] div_src0;
    logic [31:0] div_src1;
    logic [1:0]  div_op;
    logic        div_sign;
    logic        div_in_valid;
    logic        div_in_ready;
    logic        div_out_ready;
    logic        div_out_valid;
    logic [31:0] div_res0;
    logic [31:0] div_res1;

    modport master (
        output div_src0,
        output div_src1,
        output div_op,
        output div_sign,
        output div_in_valid,
        input  div_in_ready,
        output div_out_ready,
        input  div_out_valid,
        input  div_res0,
        input  div_res1
    );

    modport slave (
        input  div_src0,
        input  div_src1,
        input  div_op,
        input  div_sign,
        input  div_in_valid,
        output div_in_ready,
        input  div_out_ready,
        output div_out_valid,
        output div_res0,
        output div_res1
    );

endinterface

// File: rtl/md_mul_core.sv
// md_mul_core: operand-registered 64-bit signed/unsigned multiplier.
// Ports: clk, reset, load/sign/a/b in; a_q/b_q/sign_q/prod out.
module md_mul_core
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] a_q,
    output logic [31:0] b_q,
    output logic        sign_q,
    output logic [63:0] prod
);

    logic [31:0] a_d;
    logic [31:0] b_d;
    logic        sign_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        sign_d = sign_q;
        if (load) begin
            a_d    = a;
            b_d    = b;
            sign_d = sign;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sign_q <= sign_d;
        end
    end

    // Product settles from the held operands during MUL_RUN.
    assign prod = ext64(a_q, sign_q) * ext64(b_q, sign_q);

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: EX-stage MULT/DIV controller owning the HI/LO pair.
// Ports: clk, reset, md_start/md_op/req/rs_data/rt_data in;
// md_rd, busy out; div = divider handshake (master side).
module md_ctrl
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         md_start,
    input  logic [3:0]   md_op,
    input  logic         req,
    input  logic [31:0]  rs_data,
    input  logic [31:0]  rt_data,
    output logic [31:0]  md_rd,
    output logic         busy,
    md_ctrl_if.master    div
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_CYCLES - 1);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    md_op_e      op;
    logic        go;
    logic        is_mul;
    logic        is_div;
    logic        sign;
    logic        load;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sign_q;
    logic [63:0] prod;

    assign op     = md_op_e'(md_op);
    assign go     = md_start & ~req;
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign sign   = (op == OP_MULT) || (op == OP_DIV);

    md_mul_core u_mul (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .sign   (sign),
        .a      (rs_data),
        .b      (rt_data),
        .a_q    (a_q),
        .b_q    (b_q),
        .sign_q (sign_q),
        .prod   (prod)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (is_mul) begin
                        load    = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = S_MUL_RUN;
                    end else if (is_div && (rt_data != '0)) begin
                        load    = 1'b1;
                        state_d = S_DIV_REQ;
                    end else if (op == OP_MTHI) begin
                        hi_d = rs_data;
                    end else if (op == OP_MTLO) begin
                        lo_d = rs_data;
                    end
                end
            end
            S_MUL_RUN: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV_REQ: begin
                if (div.div_in_ready) begin
                    state_d = S_DIV_WAIT;
                end
            end
            S_DIV_WAIT: begin
                if (div.div_out_valid) begin
                    hi_d    = div.div_res1;
                    lo_d    = div.div_res0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        md_rd = '0;
        if (op == OP_MFHI) begin
            md_rd = hi_q;
        end else if (op == OP_MFLO) begin
            md_rd = lo_q;
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign div.div_in_valid  = (state_q == S_DIV_REQ);
    assign div.div_out_ready = (state_q == S_DIV_WAIT);
    assign div.div_op        = div.div_in_valid ? DOP_DIV : DOP_IDLE;
    assign div.div_src0      = a_q;
    assign div.div_src1      = b_q;
    assign div.div_sign      = sign_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed-vector bench for md_ctrl with a
// 10-cycle behavioural divider on the slave side.
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_start;
    logic [3:0]  md_op;
    logic        req;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] md_rd;
    logic        busy;

    md_ctrl_if dif ();

    md_ctrl #(.MUL_CYCLES(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_op    (md_op),
        .req      (req),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .md_rd    (md_rd),
        .busy     (busy),
        .div      (dif.master)
    );

    always #5 clk = ~clk;

    // Divider model: accepts when idle, result valid 10 cycles later.
    logic dv_busy;
    int   dv_cnt;

    function automatic logic [31:0] dq(
        input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) return $signed(a) / $signed(b);
        return a / b;
    endfunction

    function automatic logic [31:0] dr(
        input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) return $signed(a) % $signed(b);
        return a % b;
    endfunction

    assign dif.div_in_ready = ~dv_busy;

    always @(posedge clk) begin
        if (reset) begin
            dv_busy           <= 1'b0;
            dv_cnt            <= 0;
            dif.div_out_valid <= 1'b0;
            dif.div_res0      <= '0;
            dif.div_res1      <= '0;
        end else if (!dv_busy && dif.div_in_valid) begin
            dv_busy      <= 1'b1;
            dv_cnt       <= 10;
            dif.div_res0 <= dq(dif.div_src0, dif.div_src1, dif.div_sign);
            dif.div_res1 <= dr(dif.div_src0, dif.div_src1, dif.div_sign);
        end else if (dv_busy && !dif.div_out_valid) begin
            if (dv_cnt == 1) dif.div_out_valid <= 1'b1;
            else dv_cnt <= dv_cnt - 1;
        end else if (dif.div_out_valid && dif.div_out_ready) begin
            dif.div_out_valid <= 1'b0;
            dv_busy           <= 1'b0;
        end
    end

    // Cycle counters sampled on the falling edge.
    int busy_seen = 0;
    int iv_seen   = 0;
    always @(negedge clk) begin
        if (busy) busy_seen <= busy_seen + 1;
        if (dif.div_in_valid) iv_seen <= iv_seen + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h,
                             output logic [31:0] l);
        md_op = OP_MFHI;
        #1 h = md_rd;
        md_op = OP_MFLO;
        #1 l = md_rd;
        md_op = OP_NONE;
    endtask

    task automatic run_op(input md_op_e op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic r,
                          output int bn,
                          output int vn);
        int b0, v0, k;
        b0 = busy_seen;
        v0 = iv_seen;
        @(negedge clk);
        md_start = 1'b1;
        md_op    = op;
        rs_data  = a;
        rt_data  = b;
        req      = r;
        @(negedge clk);
        md_start = 1'b0;
        md_op    = OP_NONE;
        req      = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("timeout", 64'(k < 100), 64'd1);
        @(negedge clk);
        #1;
        bn = busy_seen - b0;
        vn = iv_seen - v0;
    endtask

    logic [31:0] h, l;
    int bn, vn;

    initial begin
        reset    = 1'b1;
        md_start = 1'b0;
        md_op    = OP_NONE;
        req      = 1'b0;
        rs_data  = '0;
        rt_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_iv", 64'(dif.div_in_valid), 64'd0);
        chk("rst_or", 64'(dif.div_out_ready), 64'd0);
        chk("rst_src0", 64'(dif.div_src0), 64'd0);
        chk("rst_dop", 64'(dif.div_op), 64'd0);
        read_hilo(h, l);
        chk("rst_hi", 64'(h), 64'd0);
        chk("rst_lo", 64'(l), 64'd0);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, bn, vn);
        read_hilo(h, l);
        chk("mult_busy", 64'(bn), 64'd5);
        chk("mult_hi", 64'(h), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(l), 64'hFFFF_FFEB);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bn, vn);
        read_hilo(h, l);
        chk("multu_busy", 64'(bn), 64'd5);
        chk("multu_hi", 64'(h), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(l), 64'h0000_0001);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, bn, vn);
        read_hilo(h, l);
        chk("div_busy", 64'(bn), 64'd12);
        chk("div_iv", 64'(vn), 64'd1);
        chk("div_lo", 64'(l), 64'hFFFF_FFFD);
        chk("div_hi", 64'(h), 64'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd7, 32'd2, 1'b0, bn, vn);
        read_hilo(h, l);
        chk("divu_iv", 64'(vn), 64'd1);
        chk("divu_lo", 64'(l), 64'd3);
        chk("divu_hi", 64'(h), 64'd1);

        run_op(OP_MTHI, 32'hAA, 32'd0, 1'b0, bn, vn);
        run_op(OP_MTLO, 32'hBB, 32'd0, 1'b0, bn, vn);
        run_op(OP_DIV, 32'd9, 32'd0, 1'b0, bn, vn);
        read_hilo(h, l);
        chk("dz_busy", 64'(bn), 64'd0);
        chk("dz_iv", 64'(vn), 64'd0);
        chk("dz_hi", 64'(h), 64'hAA);
        chk("dz_lo", 64'(l), 64'hBB);

        @(negedge clk);
        md_start = 1'b1;
        md_op    = OP_MTHI;
        rs_data  = 32'h1234_5678;
        @(negedge clk);
        md_start = 1'b0;
        md_op    = OP_MFHI;
        #1;
        chk("mthi_mfhi", 64'(md_rd), 64'h1234_5678);
        md_op = OP_NONE;

        run_op(OP_MULT, 32'd3, 32'd4, 1'b1, bn, vn);
        read_hilo(h, l);
        chk("req_busy", 64'(bn), 64'd0);
        chk("req_hi", 64'(h), 64'h1234_5678);
        chk("req_lo", 64'(l), 64'hBB);

        @(negedge clk);
        md_start = 1'b1;
        md_op    = OP_DIV;
        rs_data  = 32'd100;
        rt_data  = 32'd3;
        @(negedge clk);
        md_start = 1'b0;
        md_op    = OP_NONE;
        repeat (3) @(negedge clk);
        #1;
        chk("wait_or", 64'(dif.div_out_ready), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_iv", 64'(dif.div_in_valid), 64'd0);
        chk("ab_or", 64'(dif.div_out_ready), 64'd0);
        reset = 1'b0;
        read_hilo(h, l);
        chk("ab_hi", 64'(h), 64'd0);
        chk("ab_lo", 64'(l), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
